lock_session_ctrl: RTL

Session controller for the 24-bit combination lock. It takes the debounced button strobe and the 8-bit switch value, and assembles three bytes into a 24-bit candidate code. It compares the candidate against a stored, reprogrammable code and sequences the timed result LEDs, failure counting and the self-lock lockout. It sits between the debounce block and the LED/seven-segment outputs and replaces ad-hoc compare logic at top level.

---
 rtl/lock_session_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lock_session_ctrl.sv
// ---------------------------------------------------------------------------
// lock_session_ctrl
//   Session controller for a 24-bit combination lock. It collects three
//   switch bytes (byte0 first) into a candidate code and compares it with a
//   reprogrammable stored code. It also sequences the result LEDs, the
//   consecutive-failure count, the lockout and the code-programming mode.
//
// Ports
//   clk           : system clock
//   rst           : asynchronous reset, active low
//   btn_pulse     : one-cycle capture strobe from debounce
//   code_8bit     : switch byte, sampled together with btn_pulse
//   change_req    : level; a match while high enters programming mode
//   led_r / led_g : active-low result LEDs (2'b11 = off)
//   self_lock     : high while locked out
//   correct_pulse : one-cycle strobe on a match
//   false_pulse   : one-cycle strobe on a mismatch
//   byte_idx      : bytes captured so far in the current entry
//   fail_cnt      : consecutive failure count
//   prog_mode     : high while a new code is being entered
// ---------------------------------------------------------------------------
module lock_session_ctrl #(
    parameter logic [23:0] CODE_INIT      = 24'hFF00FF,
    parameter int unsigned MAX_FAIL       = 3,
    parameter int unsigned LED_CYCLES     = 25000000,
    parameter int unsigned LOCKOUT_CYCLES = 250000000,
    parameter int unsigned ENTRY_TIMEOUT  = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pulse,
    input  logic [7:0] code_8bit,
    input  logic       change_req,
    output logic [1:0] led_r,
    output logic [1:0] led_g,
    output logic       self_lock,
    output logic       correct_pulse,
    output logic       false_pulse,
    output logic [1:0] byte_idx,
    output logic [1:0] fail_cnt,
    output logic       prog_mode
);

    typedef enum logic [2:0] {
        S_IDLE, S_ENTRY, S_CHECK, S_OK, S_FAIL, S_LOCKOUT, S_PROG
    } state_t;

    // Terminal timer values: a phase of N cycles ends when the timer,
    // cleared on state entry, has counted N-1.
    localparam logic [31:0] LED_LAST  = 32'(LED_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [31:0] TO_LAST   = 32'(ENTRY_TIMEOUT - 1);
    localparam logic [1:0]  FAIL_MAX  = 2'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [23:0] entry_q, entry_d;
    logic [23:0] code_q, code_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [1:0]  fail_cnt_q, fail_cnt_d;
    logic [1:0]  led_r_q, led_r_d;
    logic [1:0]  led_g_q, led_g_d;
    logic        self_lock_q, self_lock_d;
    logic        correct_q, correct_d;
    logic        false_q, false_d;
    logic        prog_q, prog_d;
    // Strobe and switch byte are sampled together so the byte seen by the
    // FSM is always the one present with its strobe.
    logic        btn_q;
    logic [7:0]  sw_q;
    logic [23:0] new_entry;
    logic        restart;

    always_comb begin
        new_entry = entry_q;
        case (byte_idx_q)
            2'd0:    new_entry[7:0]   = sw_q;
            2'd1:    new_entry[15:8]  = sw_q;
            default: new_entry[23:16] = sw_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        code_d     = code_q;
        byte_idx_d = byte_idx_q;
        fail_cnt_d = fail_cnt_q;
        correct_d  = 1'b0;
        false_d    = 1'b0;
        restart    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (btn_q) begin
                    entry_d    = {16'h0000, sw_q};
                    byte_idx_d = 2'd1;
                    state_d    = S_ENTRY;
                end
            end
            S_ENTRY, S_PROG: begin
                // A strobe on the timeout cycle takes priority.
                if (btn_q) begin
                    entry_d = new_entry;
                    restart = 1'b1;
                    if (byte_idx_q == 2'd2) begin
                        byte_idx_d = 2'd0;
                        if (state_q == S_PROG) begin
                            code_d  = new_entry;
                            state_d = S_OK;
                        end else begin
                            state_d = S_CHECK;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end else if (timer_q == TO_LAST) begin
                    entry_d    = '0;
                    byte_idx_d = 2'd0;
                    state_d    = S_IDLE;
                end
            end
            S_CHECK: begin
                if (entry_q == code_q) begin
                    fail_cnt_d = 2'd0;
                    correct_d  = 1'b1;
                    state_d    = change_req ? S_PROG : S_OK;
                end else begin
                    false_d = 1'b1;
                    if (fail_cnt_q < FAIL_MAX)
                        fail_cnt_d = fail_cnt_q + 2'd1;
                    state_d = (fail_cnt_d == FAIL_MAX) ? S_LOCKOUT : S_FAIL;
                end
            end
            S_OK, S_FAIL: begin
                if (timer_q == LED_LAST)
                    state_d = S_IDLE;
            end
            S_LOCKOUT: begin
                // Zero duration means the lock holds until reset.
                if (LOCKOUT_CYCLES != 0 && timer_q == LOCK_LAST) begin
                    fail_cnt_d = 2'd0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Cleared on every state change; saturates so it never wraps.
        if (state_d != state_q || restart)
            timer_d = '0;
        else if (timer_q != '1)
            timer_d = timer_q + 32'd1;
        else
            timer_d = timer_q;

        // Outputs are registered from the next state so LEDs change on the
        // same edge as the state.
        led_r_d     = (state_d == S_FAIL || state_d == S_LOCKOUT) ? 2'b00 : 2'b11;
        led_g_d     = (state_d == S_OK) ? 2'b00 : 2'b11;
        self_lock_d = (state_d == S_LOCKOUT);
        prog_d      = (state_d == S_PROG);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            entry_q     <= '0;
            code_q      <= CODE_INIT;
            byte_idx_q  <= 2'd0;
            fail_cnt_q  <= 2'd0;
            led_r_q     <= 2'b11;
            led_g_q     <= 2'b11;
            self_lock_q <= 1'b0;
            correct_q   <= 1'b0;
            false_q     <= 1'b0;
            prog_q      <= 1'b0;
            btn_q       <= 1'b0;
            sw_q        <= 8'h00;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            entry_q     <= entry_d;
            code_q      <= code_d;
            byte_idx_q  <= byte_idx_d;
            fail_cnt_q  <= fail_cnt_d;
            led_r_q     <= led_r_d;
            led_g_q     <= led_g_d;
            self_lock_q <= self_lock_d;
            correct_q   <= correct_d;
            false_q     <= false_d;
            prog_q      <= prog_d;
            btn_q       <= btn_pulse;
            sw_q        <= code_8bit;
        end
    end

    assign led_r         = led_r_q;
    assign led_g         = led_g_q;
    assign self_lock     = self_lock_q;
    assign correct_pulse = correct_q;
    assign false_pulse   = false_q;
    assign byte_idx      = byte_idx_q;
    assign fail_cnt      = fail_cnt_q;
    assign prog_mode     = prog_q;

endmodule
